aemb2_memwb: RTL
================

AEMB2_MEMWB -- requirements
Module: aeMB2_memwb

Interface
REQ-001 Parameter AEMB_DWB, default 32: data bus address width.
REQ-002 Parameter AEMB_HTX, default 1: hyperthreading enable; 1 selects a 64-entry register file and 0 selects 32 entries.
REQ-003 Port gclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port grst, input, 1: asynchronous active-low reset.
REQ-005 Port dena, input, 1: pipeline advance enable.
REQ-006 Port gpha, input, 1: thread phase of the instruction being captured.
REQ-007 Port alu_mx / mul_mx / bsf_mx / sfr_mx, input, 32 each: execution unit results.
REQ-008 Port sel_mx, input, 3: result source; 000 ALU, 001 MUL, 010 BSF, 011 SFR, 100 LOAD, others none.
REQ-009 Port siz_mx, input, 2: load size; 00 byte, 01 half, 10 word.
REQ-010 Port rd_mx, input, 5: destination register.
REQ-011 Port wre_mx, input, 1: the instruction writes rd_mx.
REQ-012 Port dwb_dat_i, input, 32: load data.
REQ-013 Port dwb_ack_i, input, 1: load acknowledge.
REQ-014 Port dwb_stb_o, output, 1: load request strobe.
REQ-015 Port stall_o, output, 1: pipeline hold request.
REQ-016 Port rd_wb, output, 6: write address; bit 5 is the thread bank.
REQ-017 Port dat_wb, output, 32: write data.
REQ-018 Port wre_wb, output, 1: register-file write strobe, single-cycle pulse.
REQ-019 Ports fwd_a_of / fwd_b_of, output, 1 each; ports ra_of / rb_of, input, 5 each: forwarding hit indicators and the source registers they compare against.

Function
REQ-020 FSM states: IDLE and WAIT.
- IDLE -> WAIT when dena=1 and sel_mx=100; dwb_stb_o=1 from the next cycle.
- WAIT -> IDLE on the cycle dwb_ack_i=1 is sampled.
REQ-021 stall_o SHALL equal 1 exactly while the FSM is in WAIT and dwb_ack_i=0.
REQ-022 Non-load capture: when dena=1, IDLE, and sel_mx is in 000..011, the block SHALL register the selected result.
- dat_wb, rd_wb and wre_wb are valid one cycle later (latency 1).
REQ-023 wre_wb SHALL be 1 only if wre_mx=1 and rd_mx!=0; register 0 is never written.
REQ-024 Any sel_mx value not in 000..100 SHALL produce wre_wb=0.
REQ-025 Load alignment is big-endian, zero-extended, using byte address bits alu_mx[1:0] captured at request time.
- Byte: offset 0 selects bits 31:24, offset 3 selects bits 7:0.
- Half: offset bit 1 = 0 selects bits 31:16.
- Word: passed through unchanged.
REQ-026 On ack, the aligned load data SHALL appear on dat_wb with a wre_wb pulse on the next cycle.
REQ-027 dwb_ack_i in IDLE SHALL be ignored.
REQ-028 dena=0 SHALL hold all capture registers; a pending WAIT still completes on ack regardless of dena.
REQ-029 rd_wb[5] SHALL be the gpha sampled at capture when AEMB_HTX=1, and 0 otherwise.
REQ-030 No new capture SHALL occur in WAIT, including in the ack cycle itself.

Reset
REQ-031 While grst=0, outputs SHALL be: FSM=IDLE, dwb_stb_o=0, stall_o=0, wre_wb=0, dat_wb=0, rd_wb=0, fwd_a_of=0, fwd_b_of=0.
REQ-032 Reset asserted during WAIT SHALL abort the load immediately, drop the strobe and discard the outstanding ack.

Configuration
REQ-033 Macro AEMB2_MEMWB_FWD_EN, when defined:
- fwd_a_of=1 iff wre_wb=1 and rd_wb[4:0]=ra_of and rd_wb[5]=gpha; fwd_b_of is the same against rb_of.
- Both are combinational.
REQ-034 When AEMB2_MEMWB_FWD_EN is undefined, fwd_a_of and fwd_b_of SHALL be constant 0 and no comparators SHALL be synthesised.

Verification
REQ-035 ALU write: sel=000, alu_mx=0x12345678, rd=5, wre=1, dena=1 -> next cycle wre_wb=1, rd_wb=5, dat_wb=0x12345678.
REQ-036 Register 0 guard: sel=001, rd=0, wre=1 -> wre_wb stays 0.
REQ-037 Byte load: siz=00, alu_mx[1:0]=10, ack after 3 cycles with dwb_dat_i=0xAABBCCDD -> stall_o high for 3 cycles, then dat_wb=0x000000CC with a wre_wb pulse.
REQ-038 Half load: siz=01, alu_mx[1:0]=00, dat=0xAABBCCDD -> dat_wb=0x0000AABB.
REQ-039 Reset mid-load: grst=0 in WAIT, then ack=1 after reset release -> dwb_stb_o=0, no wre_wb pulse.
REQ-040 Forwarding with AEMB2_MEMWB_FWD_EN defined: rd_wb=7, ra_of=7, matching gpha -> fwd_a_of=1; rebuilt without the macro -> fwd_a_of=0.

Source files
------------

// File: rtl/aemb2_memwb.sv
// aemb2_memwb: memory/writeback stage. Registers execution results, runs
// the data-bus load handshake, aligns load data big-endian and produces the
// register-file write port.
// Optional macro AEMB2_MEMWB_FWD_EN adds writeback-to-operand forwarding
// hit indicators; without it fwd_a_of/fwd_b_of are tied low.
module aemb2_memwb #(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_HTX = 1
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dena,
    input  logic        gpha,
    input  logic [31:0] alu_mx,
    input  logic [31:0] mul_mx,
    input  logic [31:0] bsf_mx,
    input  logic [31:0] sfr_mx,
    input  logic [2:0]  sel_mx,
    input  logic [1:0]  siz_mx,
    input  logic [4:0]  rd_mx,
    input  logic        wre_mx,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_ack_i,
    output logic        dwb_stb_o,
    output logic        stall_o,
    output logic [5:0]  rd_wb,
    output logic [31:0] dat_wb,
    output logic        wre_wb,
    input  logic [4:0]  ra_of,
    input  logic [4:0]  rb_of,
    output logic        fwd_a_of,
    output logic        fwd_b_of
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        issue, ld_req, ld_done, exe_cap, bank;
    logic [31:0] exe_dat, ld_dat;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [1:0]  ld_off, ld_siz;
    logic [5:0]  ld_rd;
    logic        ld_wre;

    // Captures only happen from IDLE; the ack cycle itself never captures.
    assign issue   = dena && state == IDLE;
    assign ld_req  = issue && sel_mx == 3'b100;
    assign exe_cap = issue && !sel_mx[2];
    assign ld_done = state == WAIT && dwb_ack_i;
    assign bank    = (AEMB_HTX != 0) && gpha;

    // State register; reset aborts any outstanding load.
    always_ff @(posedge gclk or negedge grst)
        if (!grst) state <= IDLE;
        else state <= state_nxt;

    // Next state: enter WAIT on a load issue, leave on ack regardless of dena.
    always_comb
        state_nxt = (state == IDLE) ? (ld_req ? WAIT : IDLE) : (dwb_ack_i ? IDLE : WAIT);

    // Strobe follows WAIT; hold the pipeline until the ack arrives.
    always_comb begin
        dwb_stb_o = state == WAIT;
        stall_o   = state == WAIT && !dwb_ack_i;
    end

    // Execution unit result select for non-load instructions.
    always_comb
        exe_dat = sel_mx[1] ? (sel_mx[0] ? sfr_mx : bsf_mx) : (sel_mx[0] ? mul_mx : alu_mx);

    // Big-endian zero-extended alignment; size 11 is treated as a word.
    always_comb begin
        ld_byte = (ld_off == 2'd0) ? dwb_dat_i[31:24] :
                  (ld_off == 2'd1) ? dwb_dat_i[23:16] :
                  (ld_off == 2'd2) ? dwb_dat_i[15:8]  : dwb_dat_i[7:0];
        ld_half = ld_off[1] ? dwb_dat_i[15:0] : dwb_dat_i[31:16];
        ld_dat  = (ld_siz == 2'b00) ? {24'd0, ld_byte} :
                  (ld_siz == 2'b01) ? {16'd0, ld_half} : dwb_dat_i;
    end

    // Load context (offset, size, destination) held for the whole WAIT.
    always_ff @(posedge gclk or negedge grst)
        if (!grst) begin
            ld_off <= 2'b00;
            ld_siz <= 2'b00;
            ld_rd  <= 6'd0;
            ld_wre <= 1'b0;
        end else if (ld_req) begin
            ld_off <= (AEMB_DWB >= 2) ? alu_mx[1:0] : 2'b00;
            ld_siz <= siz_mx;
            ld_rd  <= {bank, rd_mx};
            ld_wre <= wre_mx;
        end

    // Writeback register: wre_wb pulses once per completed instruction,
    // data and address hold otherwise; register 0 is never written.
    always_ff @(posedge gclk or negedge grst)
        if (!grst) begin
            wre_wb <= 1'b0;
            dat_wb <= 32'd0;
            rd_wb  <= 6'd0;
        end else begin
            wre_wb <= ld_done ? (ld_wre && ld_rd[4:0] != 5'd0) :
                      (exe_cap && wre_mx && rd_mx != 5'd0);
            if (ld_done) begin
                dat_wb <= ld_dat;
                rd_wb  <= ld_rd;
            end else if (exe_cap) begin
                dat_wb <= exe_dat;
                rd_wb  <= {bank, rd_mx};
            end
        end

`ifdef AEMB2_MEMWB_FWD_EN
    assign fwd_a_of = wre_wb && rd_wb[4:0] == ra_of && rd_wb[5] == gpha;
    assign fwd_b_of = wre_wb && rd_wb[4:0] == rb_of && rd_wb[5] == gpha;
`else
    logic unused_fwd;
    assign unused_fwd = ^{ra_of, rb_of};
    assign fwd_a_of   = 1'b0;
    assign fwd_b_of   = 1'b0;
`endif

endmodule
